// File: rtl/fp_int_to_float_if.sv
// Start/Busy/Done handshake and operand/result bus for the int-to-float converter.
interface fp_int_to_float_if;
  logic        i_start;
  logic [31:0] i_a;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;

  modport master (output i_start, output i_a, input o_busy, input o_done, input o_result);
  modport slave  (input i_start, input i_a, output o_busy, output o_done, output o_result);
endinterface

// File: rtl/fp_int_to_float.sv
// Signed 32-bit integer to IEEE-754 single conversion, round-to-nearest-even,
// normalized one left shift per cycle.
module fp_int_to_float (
  input  logic              i_clk,
  input  logic              i_rst,
  fp_int_to_float_if.slave  bus
);
  localparam int unsigned W_INT  = 32;
  localparam int unsigned W_EXP  = 8;
  localparam int unsigned W_FRAC = 23;
  localparam logic [W_EXP-1:0] EXP_TOP = W_EXP'(158);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ZERO_CHECK, S_NORMALIZE, S_ROUND, S_PACK
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [W_INT-1:0]   r_a, w_a_nxt;
  logic               r_sgn, w_sgn_nxt;
  logic [W_INT-1:0]   r_mag, w_mag_nxt;
  logic [W_EXP-1:0]   r_exp, w_exp_nxt;
  logic [W_FRAC-1:0]  r_frac, w_frac_nxt;
  logic [W_INT-1:0]   r_result, w_result_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;

  // Rounding: an all-ones fraction that increments wraps to zero and carries into the exponent.
  logic               w_inc;
  logic               w_carry;
  logic [W_FRAC-1:0]  w_frac_rnd;

  assign w_inc      = r_mag[7] & ((|r_mag[6:0]) | r_mag[8]);
  assign w_carry    = w_inc & (&r_mag[30:8]);
  assign w_frac_rnd = r_mag[30:8] + W_FRAC'(w_inc);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_sgn    <= 1'b0;
      r_mag    <= '0;
      r_exp    <= '0;
      r_frac   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_sgn    <= w_sgn_nxt;
      r_mag    <= w_mag_nxt;
      r_exp    <= w_exp_nxt;
      r_frac   <= w_frac_nxt;
      r_result <= w_result_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_sgn_nxt    = r_sgn;
    w_mag_nxt    = r_mag;
    w_exp_nxt    = r_exp;
    w_frac_nxt   = r_frac;
    w_result_nxt = r_result;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_a_nxt     = bus.i_a;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // Negating 0x80000000 yields 0x80000000, which is exactly 2^31 unsigned.
        w_sgn_nxt   = r_a[W_INT-1];
        w_mag_nxt   = r_a[W_INT-1] ? W_INT'(-r_a) : r_a;
        w_exp_nxt   = EXP_TOP;
        w_state_nxt = S_ZERO_CHECK;
      end
      S_ZERO_CHECK: begin
        if (r_mag == '0) begin
          w_result_nxt = '0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_state_nxt  = S_NORMALIZE;
        end
      end
      S_NORMALIZE: begin
        if (r_mag[W_INT-1]) begin
          w_state_nxt = S_ROUND;
        end else begin
          w_mag_nxt = {r_mag[W_INT-2:0], 1'b0};
          w_exp_nxt = r_exp - W_EXP'(1);
        end
      end
      S_ROUND: begin
        w_frac_nxt  = w_frac_rnd;
        w_exp_nxt   = w_carry ? r_exp + W_EXP'(1) : r_exp;
        w_state_nxt = S_PACK;
      end
      S_PACK: begin
        w_result_nxt = {r_sgn, r_exp, r_frac};
        w_done_nxt   = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
  assign bus.o_result = r_result;
endmodule

// File: tb/tb_fp_int_to_float.sv
// Directed and randomized checks of fp_int_to_float against an arithmetic
// int-to-float reference with round-to-nearest-even and a 5+lz latency model.
module tb_fp_int_to_float;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  fp_int_to_float_if bus ();

  fp_int_to_float dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of the most significant set bit of a nonzero magnitude.
  function automatic int msb_pos(input longint m);
    int p;
    p = 0;
    for (int i = 0; i < 33; i++) if (m >= (longint'(1) << i)) p = i;
    return p;
  endfunction

  function automatic logic [31:0] ref_float(input logic [31:0] a);
    longint m, q, rem, half;
    int     p, s, e;
    logic   sgn;
    if (a == 32'd0) return 32'd0;
    m   = longint'($signed(a));
    sgn = (m < 0);
    if (m < 0) m = -m;
    p = msb_pos(m);
    e = 127 + p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      s    = p - 23;
      q    = m >> s;
      rem  = m - (q << s);
      half = longint'(1) << (s - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {sgn, 8'(e), 23'(q)};
  endfunction

  function automatic int ref_latency(input logic [31:0] a);
    longint m;
    if (a == 32'd0) return 2;
    m = longint'($signed(a));
    if (m < 0) m = -m;
    return 5 + (31 - msb_pos(m));
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; drives Start for one edge (the accept edge) and returns at the following negedge.
  task automatic issue(input logic [31:0] a);
    bus.i_start = 1'b1;
    bus.i_a     = a;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_a     = $urandom;
  endtask

  // Counts edges since the accept edge until Done is seen at a negedge; bounded.
  task automatic wait_done(input int n0, input bit chk_busy, output int n, output logic [31:0] res);
    bit got;
    got = 1'b0;
    n   = n0;
    while (!got && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.o_done) got = 1'b1;
      else if (chk_busy) check32("busy_mid", 32'(bus.o_busy), 32'd1);
    end
    check32("done_seen", 32'(got), 32'd1);
    if (got) check32("busy_at_done", 32'(bus.o_busy), 32'd0);
    res = bus.o_result;
  endtask

  task automatic run_dir(input string tag, input logic [31:0] a, input logic [31:0] exp_res,
                         input int exp_lat, input bit chk_busy);
    int          n;
    logic [31:0] res;
    issue(a);
    wait_done(0, chk_busy, n, res);
    check32({tag, "_res"}, res, exp_res);
    check32({tag, "_lat"}, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    int          n;
    int          dones;
    logic [31:0] res;
    logic [31:0] a;

    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a     = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_busy", 32'(bus.o_busy), 32'd0);
    check32("rst_done", 32'(bus.o_done), 32'd0);
    check32("rst_result", bus.o_result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_dir("one", 32'd1, 32'h3F80_0000, 36, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check32("done_pulse_width", 32'(bus.o_done), 32'd0);
    check32("result_hold", bus.o_result, 32'h3F80_0000);

    run_dir("minus_one", 32'hFFFF_FFFF, 32'hBF80_0000, 36, 1'b1);
    run_dir("zero", 32'd0, 32'h0000_0000, 2, 1'b1);
    run_dir("int_min", 32'h8000_0000, 32'hCF00_0000, 5, 1'b1);
    run_dir("tie_even_lo", 32'd16777217, 32'h4B80_0000, 12, 1'b0);
    run_dir("tie_round_up", 32'd16777219, 32'h4B80_0002, 12, 1'b0);
    run_dir("tie_even_hi", 32'd16777221, 32'h4B80_0002, 12, 1'b0);
    run_dir("mant_carry", 32'h7FFF_FFFF, 32'h4F00_0000, 6, 1'b0);

    // Start pulsed mid-conversion is ignored; Start in the Done cycle is accepted.
    issue(32'd5);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = 32'd9;
    @(posedge clk); @(negedge clk);
    bus.i_start = 1'b0;
    wait_done(3, 1'b1, n, res);
    check32("ignored_start_res", res, 32'h40A0_0000);
    check32("ignored_start_lat", 32'(n), 32'd34);
    run_dir("b2b_nine", 32'd9, 32'h4110_0000, 33, 1'b1);

    // Reset during NORMALIZE aborts the conversion without a Done.
    issue(32'd1);
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check32("abort_busy", 32'(bus.o_busy), 32'd0);
    check32("abort_done", 32'(bus.o_done), 32'd0);
    check32("abort_result", bus.o_result, 32'd0);
    rst   = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.o_done) dones++;
    end
    check32("abort_no_done", 32'(dones), 32'd0);
    run_dir("after_abort", 32'd3, 32'h4040_0000, 35, 1'b0);

    // Random sweep; every fourth operand is arithmetically shifted to cover long normalizations.
    for (int i = 0; i < 3000; i++) begin
      a = $urandom;
      if (i % 4 == 0) a = 32'($signed(a) >>> $urandom_range(31, 0));
      issue(a);
      wait_done(0, 1'b0, n, res);
      check32("rand_res", res, ref_float(a));
      check32("rand_lat", 32'(n), 32'(ref_latency(a)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
